wb_stage: RTL and testbench

Write-back stage that drives the register-file write port (rd address, data, write enable) from two sources. The first is the MEM/WB pipeline register: ALU result, aligned and extended load data, or PC+4. The second is a 1-entry skid buffer for late results from the multi-cycle MDU. A 32-bit scoreboard tracks MDU destinations still in flight so the ID stage can stall on them.

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/wb_stage_if.sv | 64 ++++++
 rtl/wb_stage_load_align.sv | 54 +++++
 rtl/wb_stage.sv | 160 ++++++++++++++++
 tb/tb_wb_stage.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the integer pipeline back end:
//   wb_sel_e  : write-back source select (ALU result, load data, PC+4)
//   F3_*      : funct3 encodings of the load instructions
//   mem_wb_t  : contents of the MEM/WB pipeline register
//   rd_writes : true when a MEM/WB entry really updates the register file
// -----------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef struct packed {
    logic        valid;
    logic        wren;
    logic [4:0]  rd;
    logic [31:0] data;
  } mem_wb_t;

  // x0 is hard-wired, so an entry targeting it never counts as a write.
  function automatic logic rd_writes(input mem_wb_t e);
    return e.valid & e.wren & (e.rd != 5'd0);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if
// Bundles every non-clock signal of the write-back stage:
//   MEM-side inputs (instruction, load word, PC+4) and the MEM stall back,
//   MDU result handshake (valid/ready) and MDU issue notification,
//   ID-stage scoreboard queries and their busy answers,
//   register-file write port.
// Modports: slave = the write-back stage, master = its environment.
// -----------------------------------------------------------------------------
interface wb_stage_if;
  import riscv_pkg::*;

  // MEM stage
  logic        i_mem_valid;
  logic        i_mem_rd_wren;
  logic [4:0]  i_mem_rd_addr;
  logic [1:0]  i_mem_wb_sel;
  logic [31:0] i_mem_alu_data;
  logic [31:0] i_mem_ld_word;
  logic [1:0]  i_mem_addr_lo;
  logic [2:0]  i_mem_funct3;
  logic [31:0] i_mem_pc4;
  logic        o_stall_mem;

  // MDU
  logic        i_mdu_issue;
  logic [4:0]  i_mdu_issue_rd;
  logic        i_mdu_valid;
  logic [4:0]  i_mdu_rd_addr;
  logic [31:0] i_mdu_data;
  logic        o_mdu_ready;

  // scoreboard queries
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic [4:0]  i_id_rd_addr;
  logic        o_rs1_busy;
  logic        o_rs2_busy;
  logic        o_rd_busy;

  // register-file write port
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;

  modport slave (
    input  i_mem_valid, i_mem_rd_wren, i_mem_rd_addr, i_mem_wb_sel,
           i_mem_alu_data, i_mem_ld_word, i_mem_addr_lo, i_mem_funct3, i_mem_pc4,
           i_mdu_issue, i_mdu_issue_rd, i_mdu_valid, i_mdu_rd_addr, i_mdu_data,
           i_rs1_addr, i_rs2_addr, i_id_rd_addr,
    output o_stall_mem, o_mdu_ready, o_rs1_busy, o_rs2_busy, o_rd_busy,
           o_rd_addr, o_rd_data, o_rd_wren
  );

  modport master (
    output i_mem_valid, i_mem_rd_wren, i_mem_rd_addr, i_mem_wb_sel,
           i_mem_alu_data, i_mem_ld_word, i_mem_addr_lo, i_mem_funct3, i_mem_pc4,
           i_mdu_issue, i_mdu_issue_rd, i_mdu_valid, i_mdu_rd_addr, i_mdu_data,
           i_rs1_addr, i_rs2_addr, i_id_rd_addr,
    input  o_stall_mem, o_mdu_ready, o_rs1_busy, o_rs2_busy, o_rd_busy,
           o_rd_addr, o_rd_data, o_rd_wren
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load formatter: picks the byte/halfword addressed by the low
// address bits out of a word-aligned load and sign- or zero-extends it.
// Ports:
//   word_i    : raw word-aligned load data
//   addr_lo_i : byte offset within the word
//   funct3_i  : load type (LB/LH/LW/LBU/LHU; anything else passes the word)
//   data_o    : formatted 32-bit result
// -----------------------------------------------------------------------------
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte and halfword lane selection.
  always_comb begin
    byte_s = word_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      2'd3:    byte_s = word_i[31:24];
      default: byte_s = word_i[7:0];
    endcase
    // halfwords are assumed aligned, so only addr_lo[1] matters
    if (addr_lo_i[1]) begin
      half_s = word_i[31:16];
    end else begin
      half_s = word_i[15:0];
    end
  end

  // Extension according to the load type.
  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_s[7]}}, byte_s};
      F3_LBU:  data_o = {24'd0, byte_s};
      F3_LH:   data_o = {{16{half_s[15]}}, half_s};
      F3_LHU:  data_o = {16'd0, half_s};
      F3_LW:   data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back stage. Drives the register-file write port from either the
// MEM/WB pipeline register or a one-entry skid buffer holding a late MDU
// result. The pipeline normally wins; a buffered result that has lost
// MAX_WAIT times in a row stalls the MEM stage for one cycle to drain.
// A 32-bit scoreboard marks registers with an MDU write still in flight.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus            : wb_stage_if.slave (MEM inputs/stall, MDU handshake,
//                    scoreboard queries, register-file write port)
// Parameter:
//   MAX_WAIT       : arbitration losses tolerated by the buffer (1..15)
// -----------------------------------------------------------------------------
module wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 32'd4
) (
  input  logic      i_clk,
  input  logic      i_reset,
  wb_stage_if.slave bus
);

  localparam logic [3:0] MAX_WAIT_W = 4'(MAX_WAIT);

  mem_wb_t     mem_wb_q, mem_wb_d;
  logic        buf_valid_q, buf_valid_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] sb_q, sb_d;

  logic [31:0] load_data_s;
  logic [31:0] mem_data_s;
  logic        pipe_wr_s;
  logic        drain_s;
  logic        stall_s;
  logic        accept_s;

  load_align u_load_align (
    .word_i    (bus.i_mem_ld_word),
    .addr_lo_i (bus.i_mem_addr_lo),
    .funct3_i  (bus.i_mem_funct3),
    .data_o    (load_data_s)
  );

  // MEM-side result select; the reserved encoding falls back to the ALU.
  always_comb begin
    mem_data_s = bus.i_mem_alu_data;
    case (bus.i_mem_wb_sel)
      WB_LOAD: mem_data_s = load_data_s;
      WB_PC4:  mem_data_s = bus.i_mem_pc4;
      default: mem_data_s = bus.i_mem_alu_data;
    endcase
  end

  // Arbitration between the pipeline register and the skid buffer.
  assign pipe_wr_s = rd_writes(mem_wb_q);
  assign drain_s   = buf_valid_q & (~pipe_wr_s | (wait_q == MAX_WAIT_W));
  assign stall_s   = drain_s & pipe_wr_s;
  // ready is simply "empty", so a draining buffer cannot accept this cycle
  assign accept_s  = bus.i_mdu_valid & ~buf_valid_q & (bus.i_mdu_rd_addr != 5'd0);

  assign bus.o_stall_mem = stall_s;
  assign bus.o_mdu_ready = ~buf_valid_q;

  // Busy queries see the current scoreboard; x0 is never busy.
  assign bus.o_rs1_busy = sb_q[bus.i_rs1_addr]   & (bus.i_rs1_addr   != 5'd0);
  assign bus.o_rs2_busy = sb_q[bus.i_rs2_addr]   & (bus.i_rs2_addr   != 5'd0);
  assign bus.o_rd_busy  = sb_q[bus.i_id_rd_addr] & (bus.i_id_rd_addr != 5'd0);

  // Register-file write port mux; idle port presents all zeros.
  always_comb begin
    bus.o_rd_wren = 1'b0;
    bus.o_rd_addr = 5'd0;
    bus.o_rd_data = 32'd0;
    if (drain_s) begin
      bus.o_rd_wren = 1'b1;
      bus.o_rd_addr = buf_rd_q;
      bus.o_rd_data = buf_data_q;
    end else if (pipe_wr_s) begin
      bus.o_rd_wren = 1'b1;
      bus.o_rd_addr = mem_wb_q.rd;
      bus.o_rd_data = mem_wb_q.data;
    end else begin
      bus.o_rd_wren = 1'b0;
    end
  end

  // Next-state for pipeline register, skid buffer, wait counter, scoreboard.
  always_comb begin
    mem_wb_d    = mem_wb_q;
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    wait_d      = wait_q;
    sb_d        = sb_q;

    if (!stall_s) begin
      mem_wb_d.valid = bus.i_mem_valid;
      mem_wb_d.wren  = bus.i_mem_rd_wren;
      mem_wb_d.rd    = bus.i_mem_rd_addr;
      mem_wb_d.data  = mem_data_s;
    end else begin
      mem_wb_d = mem_wb_q;
    end

    if (drain_s) begin
      buf_valid_d = 1'b0;
      wait_d      = 4'd0;
    end else if (accept_s) begin
      buf_valid_d = 1'b1;
      buf_rd_d    = bus.i_mdu_rd_addr;
      buf_data_d  = bus.i_mdu_data;
    end else begin
      buf_valid_d = buf_valid_q;
    end

    // counts only losses of a full buffer; saturates at the field maximum
    if (!drain_s && pipe_wr_s && buf_valid_q && (wait_q != 4'hF)) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = drain_s ? 4'd0 : wait_q;
    end

    // clear first so a same-register issue in this cycle wins
    if (drain_s) begin
      sb_d[buf_rd_q] = 1'b0;
    end else begin
      sb_d = sb_q;
    end
    if (bus.i_mdu_issue && (bus.i_mdu_issue_rd != 5'd0)) begin
      sb_d[bus.i_mdu_issue_rd] = 1'b1;
    end else begin
      sb_d[0] = 1'b0;
    end
    sb_d[0] = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mem_wb_q    <= '0;
      buf_valid_q <= 1'b0;
      buf_rd_q    <= 5'd0;
      buf_data_q  <= 32'd0;
      wait_q      <= 4'd0;
      sb_q        <= 32'd0;
    end else begin
      mem_wb_q    <= mem_wb_d;
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      wait_q      <= wait_d;
      sb_q        <= sb_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the write-back rules.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if bus();

  wb_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          rd;
    logic [31:0] data;
  } mdu_res_t;

  bit          m_wb_valid;
  bit          m_wb_wren;
  int          m_wb_rd;
  logic [31:0] m_wb_data;
  mdu_res_t    m_buf[$];
  int          m_wait;
  bit          m_busy[32];

  // observations from the most recent tick
  logic        obs_wren, obs_stall, obs_ready, obs_rs1, obs_rs2, obs_rdb;
  logic [4:0]  obs_addr;
  logic [31:0] obs_data;

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int lo, input int f3);
    longint v;
    longint wl;
    wl = longint'(w);
    case (f3)
      0: begin v = (wl >> (8 * lo)) & 255;  if (v >= 128)   v = v - 256;   end
      4: v = (wl >> (8 * lo)) & 255;
      1: begin v = (wl >> (16 * (lo / 2))) & 65535; if (v >= 32768) v = v - 65536; end
      5: v = (wl >> (16 * (lo / 2))) & 65535;
      default: v = wl;
    endcase
    return v[31:0];
  endfunction

  task automatic model_reset();
    m_wb_valid = 0; m_wb_wren = 0; m_wb_rd = 0; m_wb_data = 32'd0;
    m_buf.delete();
    m_wait = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
  endtask

  task automatic set_idle();
    rst = 1'b0;
    bus.i_mem_valid = 1'b0; bus.i_mem_rd_wren = 1'b0; bus.i_mem_rd_addr = 5'd0;
    bus.i_mem_wb_sel = 2'd0; bus.i_mem_alu_data = 32'd0; bus.i_mem_ld_word = 32'd0;
    bus.i_mem_addr_lo = 2'd0; bus.i_mem_funct3 = 3'd0; bus.i_mem_pc4 = 32'd0;
    bus.i_mdu_issue = 1'b0; bus.i_mdu_issue_rd = 5'd0;
    bus.i_mdu_valid = 1'b0; bus.i_mdu_rd_addr = 5'd0; bus.i_mdu_data = 32'd0;
    bus.i_rs1_addr = 5'd0; bus.i_rs2_addr = 5'd0; bus.i_id_rd_addr = 5'd0;
  endtask

  task automatic drive_mem(input int rd, input int sel, input logic [31:0] alu,
                           input logic [31:0] word, input int lo, input int f3);
    bus.i_mem_valid = 1'b1; bus.i_mem_rd_wren = 1'b1; bus.i_mem_rd_addr = 5'(rd);
    bus.i_mem_wb_sel = 2'(sel); bus.i_mem_alu_data = alu; bus.i_mem_ld_word = word;
    bus.i_mem_addr_lo = 2'(lo); bus.i_mem_funct3 = 3'(f3); bus.i_mem_pc4 = alu + 32'd4;
  endtask

  // One clock cycle: inputs already driven (called just after a negedge).
  task automatic tick();
    bit pw, dr, rdy;
    int f3, sel;
    logic [31:0] nd;
    #1;
    obs_wren = bus.o_rd_wren;   obs_stall = bus.o_stall_mem; obs_ready = bus.o_mdu_ready;
    obs_addr = bus.o_rd_addr;   obs_data  = bus.o_rd_data;
    obs_rs1  = bus.o_rs1_busy;  obs_rs2   = bus.o_rs2_busy;  obs_rdb   = bus.o_rd_busy;

    pw  = m_wb_valid && m_wb_wren && (m_wb_rd != 0);
    rdy = (m_buf.size() == 0);
    dr  = !rdy && (!pw || m_wait == MAX_WAIT);
    check_eq("wren",  32'(obs_wren),  32'(dr || pw));
    check_eq("stall", 32'(obs_stall), 32'(dr && pw));
    check_eq("ready", 32'(obs_ready), 32'(rdy));
    if (dr) begin
      check_eq("addr_mdu", 32'(obs_addr), 32'(m_buf[0].rd));
      check_eq("data_mdu", obs_data, m_buf[0].data);
    end else if (pw) begin
      check_eq("addr_pipe", 32'(obs_addr), 32'(m_wb_rd));
      check_eq("data_pipe", obs_data, m_wb_data);
    end
    check_eq("rs1_busy", 32'(obs_rs1), 32'(bus.i_rs1_addr   != 0 && m_busy[bus.i_rs1_addr]));
    check_eq("rs2_busy", 32'(obs_rs2), 32'(bus.i_rs2_addr   != 0 && m_busy[bus.i_rs2_addr]));
    check_eq("rd_busy",  32'(obs_rdb), 32'(bus.i_id_rd_addr != 0 && m_busy[bus.i_id_rd_addr]));

    if (rst) begin
      model_reset();
    end else begin
      if (dr) begin
        m_busy[m_buf[0].rd] = 0;
        void'(m_buf.pop_front());
        m_wait = 0;
      end else if (pw && !rdy && m_wait < 15) begin
        m_wait++;
      end
      if (bus.i_mdu_valid && rdy && bus.i_mdu_rd_addr != 0)
        m_buf.push_back('{int'(bus.i_mdu_rd_addr), bus.i_mdu_data});
      if (bus.i_mdu_issue && bus.i_mdu_issue_rd != 0) m_busy[bus.i_mdu_issue_rd] = 1;
      if (!(dr && pw)) begin
        sel = int'(bus.i_mem_wb_sel);
        f3  = int'(bus.i_mem_funct3);
        if (sel == 1)      nd = ref_load(bus.i_mem_ld_word, int'(bus.i_mem_addr_lo), f3);
        else if (sel == 2) nd = bus.i_mem_pc4;
        else               nd = bus.i_mem_alu_data;
        m_wb_valid = bus.i_mem_valid; m_wb_wren = bus.i_mem_rd_wren;
        m_wb_rd = int'(bus.i_mem_rd_addr); m_wb_data = nd;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  int exp_seq[7];
  int exp_stl[7];
  int nxt;

  initial begin
    set_idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    // reset state
    check_eq("rst_wren",  32'(bus.o_rd_wren),   32'd0);
    check_eq("rst_addr",  32'(bus.o_rd_addr),   32'd0);
    check_eq("rst_data",  bus.o_rd_data,        32'd0);
    check_eq("rst_stall", 32'(bus.o_stall_mem), 32'd0);
    check_eq("rst_ready", 32'(bus.o_mdu_ready), 32'd1);
    set_idle();
    tick();

    // load extension
    drive_mem(7, 1, 32'd0, 32'h80FF_1234, 3, 0); tick();
    set_idle(); tick();
    check_eq("lb",  obs_data, 32'hFFFF_FF80);
    drive_mem(7, 1, 32'd0, 32'h80FF_1234, 3, 4); tick();
    set_idle(); tick();
    check_eq("lbu", obs_data, 32'h0000_0080);
    drive_mem(7, 1, 32'd0, 32'h80FF_1234, 2, 1); tick();
    set_idle(); tick();
    check_eq("lh",  obs_data, 32'hFFFF_80FF);

    // free-slot drain
    set_idle(); bus.i_mdu_issue = 1'b1; bus.i_mdu_issue_rd = 5'd9; tick();
    set_idle(); bus.i_mdu_valid = 1'b1; bus.i_mdu_rd_addr = 5'd9; bus.i_mdu_data = 32'hDEAD_BEEF;
    tick();
    set_idle(); bus.i_rs1_addr = 5'd9; tick();
    check_eq("drain_wren", 32'(obs_wren), 32'd1);
    check_eq("drain_addr", 32'(obs_addr), 32'd9);
    check_eq("drain_data", obs_data, 32'hDEAD_BEEF);
    check_eq("drain_busy_before", 32'(obs_rs1), 32'd1);
    set_idle(); bus.i_rs1_addr = 5'd9; tick();
    check_eq("drain_ready", 32'(obs_ready), 32'd1);
    check_eq("drain_busy",  32'(obs_rs1),   32'd0);

    // starvation: buffer full while pipeline writes x1..x6 back-to-back
    exp_seq = '{1, 2, 3, 4, 10, 5, 6};
    exp_stl = '{0, 0, 0, 0, 1, 0, 0};
    set_idle();
    bus.i_mdu_valid = 1'b1; bus.i_mdu_rd_addr = 5'd10; bus.i_mdu_data = 32'h1234_5678;
    drive_mem(1, 0, 32'd101, 32'd0, 0, 0);
    tick();
    nxt = 2;
    for (int c = 0; c < 7; c++) begin
      set_idle();
      if (nxt <= 6) drive_mem(nxt, 0, 32'(100 + nxt), 32'd0, 0, 0);
      tick();
      check_eq("starve_addr",  32'(obs_addr),  32'(exp_seq[c]));
      check_eq("starve_stall", 32'(obs_stall), 32'(exp_stl[c]));
      if (!obs_stall && nxt <= 6) nxt++;
    end

    // scoreboard race: issue x3 while an older x3 result drains
    set_idle(); bus.i_mdu_issue = 1'b1; bus.i_mdu_issue_rd = 5'd3; tick();
    set_idle(); bus.i_mdu_valid = 1'b1; bus.i_mdu_rd_addr = 5'd3; bus.i_mdu_data = 32'h0000_0033;
    tick();
    set_idle(); bus.i_mdu_issue = 1'b1; bus.i_mdu_issue_rd = 5'd3; tick();
    check_eq("race_drain", 32'(obs_addr), 32'd3);
    set_idle(); bus.i_rs1_addr = 5'd3; tick();
    check_eq("race_busy", 32'(obs_rs1), 32'd1);
    // a plain result for x3 releases it again
    set_idle(); bus.i_mdu_valid = 1'b1; bus.i_mdu_rd_addr = 5'd3; tick();
    set_idle(); tick(); set_idle(); tick();

    // x0 filter
    for (int c = 0; c < 3; c++) begin
      set_idle();
      drive_mem(0, 0, 32'hFFFF_FFFF, 32'd0, 0, 0);
      bus.i_mdu_valid = 1'b1; bus.i_mdu_rd_addr = 5'd0; bus.i_mdu_data = 32'h5555_AAAA;
      bus.i_mdu_issue = 1'b1; bus.i_mdu_issue_rd = 5'd0;
      tick();
      check_eq("x0_wren",  32'(obs_wren),  32'd0);
      check_eq("x0_ready", 32'(obs_ready), 32'd1);
    end
    set_idle(); tick();
    check_eq("x0_wren_after", 32'(obs_wren), 32'd0);
    check_eq("x0_ready_after", 32'(obs_ready), 32'd1);

    // reset mid-operation: buffer full, x5 busy
    set_idle();
    bus.i_mdu_issue = 1'b1; bus.i_mdu_issue_rd = 5'd5;
    bus.i_mdu_valid = 1'b1; bus.i_mdu_rd_addr = 5'd12; bus.i_mdu_data = 32'h0BAD_F00D;
    drive_mem(1, 0, 32'd77, 32'd0, 0, 0);
    tick();
    set_idle(); drive_mem(2, 0, 32'd78, 32'd0, 0, 0); rst = 1'b1; bus.i_rs1_addr = 5'd5;
    tick();
    check_eq("pre_rst_ready", 32'(obs_ready), 32'd0);
    check_eq("pre_rst_busy",  32'(obs_rs1),   32'd1);
    set_idle(); bus.i_rs1_addr = 5'd5; tick();
    check_eq("post_rst_wren",  32'(obs_wren),  32'd0);
    check_eq("post_rst_ready", 32'(obs_ready), 32'd1);
    check_eq("post_rst_busy",  32'(obs_rs1),   32'd0);

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      bus.i_mem_valid    = ($urandom_range(0, 3) != 0);
      bus.i_mem_rd_wren  = ($urandom_range(0, 3) != 0);
      bus.i_mem_rd_addr  = 5'($urandom_range(0, 7));
      bus.i_mem_wb_sel   = 2'($urandom_range(0, 3));
      bus.i_mem_alu_data = $urandom;
      bus.i_mem_ld_word  = $urandom;
      bus.i_mem_addr_lo  = 2'($urandom_range(0, 3));
      bus.i_mem_funct3   = 3'($urandom_range(0, 7));
      bus.i_mem_pc4      = $urandom;
      bus.i_mdu_issue    = ($urandom_range(0, 3) == 0);
      bus.i_mdu_issue_rd = 5'($urandom_range(0, 7));
      bus.i_mdu_valid    = ($urandom_range(0, 2) == 0);
      bus.i_mdu_rd_addr  = 5'($urandom_range(0, 7));
      bus.i_mdu_data     = $urandom;
      bus.i_rs1_addr     = 5'($urandom_range(0, 7));
      bus.i_rs2_addr     = 5'($urandom_range(0, 7));
      bus.i_id_rd_addr   = 5'($urandom_range(0, 31));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
